// File: rtl/seq_multiplier.sv
// Sequential shift-add multiplier with a valid/ready handshake on both sides.
// Each BUSY cycle consumes K bits of the multiplier, LSB first, so a product
// takes N/K cycles. The full 2N-bit product is held until the consumer takes it.
// Optional feature macro: MUL_SIGNED_EN. When it is defined, in_signed selects
// two's complement operands. The magnitudes are multiplied and the product is
// negated when the operand signs differ. When it is undefined, every product is
// unsigned and in_signed is ignored.
module seq_multiplier #(
  parameter int N = 64,
  parameter int K = 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [N-1:0]   in_a,
  input  logic [N-1:0]   in_b,
  input  logic           in_signed,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*N-1:0] out_result,
  output logic           busy
);

  localparam int STEPS = N / K;
  localparam int CW    = $clog2(STEPS + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2*N-1:0]  acc_q, acc_d;
  logic [2*N-1:0]  mcand_q, mcand_d;
  logic [N-1:0]    mplier_q, mplier_d;
  logic [2*N-1:0]  result_q, result_d;

  logic [N-1:0]    a_op;
  logic [N-1:0]    b_op;
  logic [2*N-1:0]  step_sum;
  logic [2*N-1:0]  final_prod;

`ifdef MUL_SIGNED_EN
  logic            neg_q, neg_d;
  logic            neg_in;

  // Take the magnitudes of the incoming operands. Negating -2^(N-1) yields
  // 2^(N-1) as an unsigned N-bit value, so the most negative operand is exact.
  always_comb begin
    a_op   = (in_signed && in_a[N-1]) ? -in_a : in_a;
    b_op   = (in_signed && in_b[N-1]) ? -in_b : in_b;
    neg_in = in_signed && (in_a[N-1] ^ in_b[N-1]);
  end
`else
  logic            unused_signed;

  // The operands pass straight through because the unsigned build has no sign handling.
  always_comb begin
    a_op = in_a;
    b_op = in_b;
  end

  assign unused_signed = in_signed;
`endif

  // Add the shifted multiplicand once for each set bit in the low K multiplier bits.
  always_comb begin
    step_sum = acc_q;
    for (int j = 0; j < K; j++) begin
      if (mplier_q[j]) begin
        step_sum = step_sum + (mcand_q << j);
      end
    end
  end

  // Restore the sign on the final step when the operand signs differed.
`ifdef MUL_SIGNED_EN
  always_comb begin
    final_prod = neg_q ? -step_sum : step_sum;
  end
`else
  always_comb begin
    final_prod = step_sum;
  end
`endif

  // Compute the next state and the datapath: load on accept, step in BUSY, hold in DONE.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    result_d = result_q;
`ifdef MUL_SIGNED_EN
    neg_d    = neg_q;
`endif
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          state_d  = BUSY;
          cnt_d    = '0;
          acc_d    = '0;
          mcand_d  = {{N{1'b0}}, a_op};
          mplier_d = b_op;
`ifdef MUL_SIGNED_EN
          neg_d    = neg_in;
`endif
        end
      end
      BUSY: begin
        acc_d    = step_sum;
        mcand_d  = mcand_q << K;
        mplier_d = mplier_q >> K;
        cnt_d    = cnt_q + CW'(1);
        if (cnt_q == CW'(STEPS - 1)) begin
          state_d  = DONE;
          result_d = final_prod;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State register. A synchronous reset discards any operation in progress.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      result_q <= '0;
`ifdef MUL_SIGNED_EN
      neg_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      result_q <= result_d;
`ifdef MUL_SIGNED_EN
      neg_q    <= neg_d;
`endif
    end
  end

  assign in_ready   = (state_q == IDLE);
  assign out_valid  = (state_q == DONE);
  assign busy       = (state_q != IDLE);
  assign out_result = result_q;

endmodule

// File: tb/tb_seq_multiplier.sv
// Self-checking bench for seq_multiplier. Three instances share one stimulus:
// N=8/K=1, N=8/K=2 and N=64/K=4. The 8-bit instances use the low byte of the
// shared operands. Expected products come from plain modular arithmetic on
// extended operands. The bench follows the MUL_SIGNED_EN macro.
module tb_seq_multiplier;

`ifdef MUL_SIGNED_EN
  localparam bit SIGNED_EN = 1'b1;
`else
  localparam bit SIGNED_EN = 1'b0;
`endif

  localparam int NS  [3] = '{8, 8, 64};
  localparam int LAT [3] = '{8, 4, 16};
  localparam int MAX_WAIT = 20;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [63:0] in_a;
  logic [63:0] in_b;
  logic        in_signed;
  logic        out_ready;

  logic [2:0]   rdy;
  logic [2:0]   ov;
  logic [2:0]   bz;
  logic [15:0]  r0;
  logic [15:0]  r1;
  logic [127:0] r2;
  logic [127:0] res [3];

  int checks;
  int failures;

  seq_multiplier #(.N(8), .K(1)) dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy[0]),
    .in_a(in_a[7:0]), .in_b(in_b[7:0]), .in_signed(in_signed),
    .out_valid(ov[0]), .out_ready(out_ready), .out_result(r0), .busy(bz[0])
  );

  seq_multiplier #(.N(8), .K(2)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy[1]),
    .in_a(in_a[7:0]), .in_b(in_b[7:0]), .in_signed(in_signed),
    .out_valid(ov[1]), .out_ready(out_ready), .out_result(r1), .busy(bz[1])
  );

  seq_multiplier #(.N(64), .K(4)) dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy[2]),
    .in_a(in_a), .in_b(in_b), .in_signed(in_signed),
    .out_valid(ov[2]), .out_ready(out_ready), .out_result(r2), .busy(bz[2])
  );

  assign res[0] = {112'd0, r0};
  assign res[1] = {112'd0, r1};
  assign res[2] = r2;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference product. Each operand is extended to 128 bits, the extended
  // values are multiplied modulo 2^128, and the result is reduced to 2n bits.
  function automatic logic [127:0] model(input int n, input logic [63:0] a,
                                         input logic [63:0] b, input bit s);
    logic [127:0] ea;
    logic [127:0] eb;
    logic [127:0] mask;
    ea = '0;
    eb = '0;
    for (int i = 0; i < n; i++) begin
      ea[i] = a[i];
      eb[i] = b[i];
    end
    if (SIGNED_EN && s) begin
      if (a[n-1]) ea = ea - (128'd1 << n);
      if (b[n-1]) eb = eb - (128'd1 << n);
    end
    if (n == 64) mask = '1;
    else         mask = (128'd1 << (2 * n)) - 128'd1;
    return (ea * eb) & mask;
  endfunction

  // Run one full operation on all three instances. The task checks acceptance,
  // latency, the product and the return to IDLE.
  task automatic run_op(input logic [63:0] a, input logic [63:0] b, input bit s);
    logic [127:0] exp_r [3];
    int first [3];
    for (int i = 0; i < 3; i++) begin
      exp_r[i] = model(NS[i], a, b, s);
      first[i] = -1;
    end
    checks++;
    if (rdy !== 3'b111) begin
      failures++;
      $display("[TB] FAIL in_ready_before_op: got %b expected 111", rdy);
    end
    in_a = a; in_b = b; in_signed = s; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_a = {$urandom, $urandom};
    in_b = {$urandom, $urandom};
    in_signed = ~s;
    checks++;
    if (bz !== 3'b111 || rdy !== 3'b000) begin
      failures++;
      $display("[TB] FAIL busy_after_accept: got busy=%b in_ready=%b expected 111/000", bz, rdy);
    end
    for (int c = 1; c <= MAX_WAIT; c++) begin
      @(posedge clk); #1;
      for (int i = 0; i < 3; i++) begin
        if (ov[i] === 1'b1 && first[i] < 0) first[i] = c;
      end
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (first[i] != LAT[i]) begin
        failures++;
        $display("[TB] FAIL latency[%0d]: got %0d edges expected %0d", i, first[i], LAT[i]);
      end
      checks++;
      if (res[i] !== exp_r[i]) begin
        failures++;
        $display("[TB] FAIL product[%0d] a=%h b=%h s=%0d: got %h expected %h",
                 i, a, b, s, res[i], exp_r[i]);
      end
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checks++;
    if (rdy !== 3'b111 || ov !== 3'b000) begin
      failures++;
      $display("[TB] FAIL release: got in_ready=%b out_valid=%b expected 111/000", rdy, ov);
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (res[i] !== exp_r[i]) begin
        failures++;
        $display("[TB] FAIL idle_hold[%0d]: got %h expected %h", i, res[i], exp_r[i]);
      end
    end
  endtask

  // Check the reset state. An in_valid asserted while reset is high must be ignored.
  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b1;
    in_a = {$urandom, $urandom}; in_b = {$urandom, $urandom};
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0; in_valid = 1'b0;
    checks++;
    if (rdy !== 3'b111 || ov !== 3'b000 || bz !== 3'b000) begin
      failures++;
      $display("[TB] FAIL reset_flags: got rdy=%b ov=%b busy=%b expected 111/000/000", rdy, ov, bz);
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (res[i] !== 128'd0) begin
        failures++;
        $display("[TB] FAIL reset_result[%0d]: got %h expected 0", i, res[i]);
      end
    end
    @(posedge clk); #1;
    checks++;
    if (rdy !== 3'b111) begin
      failures++;
      $display("[TB] FAIL reset_idle_stays: got %b expected 111", rdy);
    end
  endtask

  // Directed corner operands: all ones, the most negative value, zero and wide shifts.
  task automatic test_directed();
    run_op(64'hFF, 64'hFF, 1'b0);
    run_op(64'hFF, 64'hFF, 1'b1);
    run_op(64'h80, 64'h01, 1'b1);
    run_op(64'h80, 64'h80, 1'b1);
    run_op(64'h0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
    run_op(64'hFFFF_FFFF_FFFF_FF00, 64'h0, 1'b1);
    run_op(64'h0000_0001_0000_0000, 64'h0000_0001_0000_0000, 1'b0);
    run_op(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b1);
    run_op(64'h8000_0000_0000_0080, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
    run_op(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
  endtask

  // Random operations issued back to back. Each op is offered on the cycle
  // right after the previous handshake.
  task automatic test_back_to_back();
    logic [63:0] a;
    logic [63:0] b;
    for (int t = 0; t < 24; t++) begin
      a = {$urandom, $urandom};
      b = {$urandom, $urandom};
      case ($urandom_range(0, 5))
        0: a = 64'h8000_0000_0000_0080;
        1: b = 64'h0;
        2: a = 64'hFFFF_FFFF_FFFF_FFFF;
        default: ;
      endcase
      run_op(a, b, 1'($urandom_range(0, 1)));
    end
  endtask

  // Hold the result under back-pressure while a new request is offered, then release it.
  task automatic test_back_pressure();
    logic [63:0] a;
    logic [63:0] b;
    logic [127:0] exp_r [3];
    a = {$urandom, $urandom};
    b = {$urandom, $urandom};
    for (int i = 0; i < 3; i++) exp_r[i] = model(NS[i], a, b, 1'b1);
    in_a = a; in_b = b; in_signed = 1'b1; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (MAX_WAIT) @(posedge clk);
    #1;
    in_valid = 1'b1;
    in_a = {$urandom, $urandom}; in_b = {$urandom, $urandom};
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      checks++;
      if (ov !== 3'b111 || rdy !== 3'b000) begin
        failures++;
        $display("[TB] FAIL bp_flags cycle %0d: got ov=%b rdy=%b expected 111/000", c, ov, rdy);
      end
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (res[i] !== exp_r[i]) begin
          failures++;
          $display("[TB] FAIL bp_result[%0d] cycle %0d: got %h expected %h", i, c, res[i], exp_r[i]);
        end
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checks++;
    if (rdy !== 3'b111 || ov !== 3'b000) begin
      failures++;
      $display("[TB] FAIL bp_release: got rdy=%b ov=%b expected 111/000", rdy, ov);
    end
    @(posedge clk); #1;
    checks++;
    if (rdy !== 3'b111 || bz !== 3'b000) begin
      failures++;
      $display("[TB] FAIL bp_no_queue: got rdy=%b busy=%b expected 111/000", rdy, bz);
    end
  endtask

  // Reset at step 3 of the 8-step instance. The operation is dropped and never completes.
  task automatic test_reset_mid_op();
    bit saw_valid;
    in_a = 64'hFF; in_b = 64'hFF; in_signed = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1; in_valid = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; in_valid = 1'b0;
    checks++;
    if (rdy !== 3'b111 || bz !== 3'b000 || ov !== 3'b000) begin
      failures++;
      $display("[TB] FAIL midrst_flags: got rdy=%b busy=%b ov=%b expected 111/000/000", rdy, bz, ov);
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (res[i] !== 128'd0) begin
        failures++;
        $display("[TB] FAIL midrst_result[%0d]: got %h expected 0", i, res[i]);
      end
    end
    saw_valid = 1'b0;
    for (int c = 0; c < MAX_WAIT; c++) begin
      @(posedge clk); #1;
      if (ov !== 3'b000 || rdy !== 3'b111) saw_valid = 1'b1;
    end
    checks++;
    if (saw_valid) begin
      failures++;
      $display("[TB] FAIL midrst_aborted: got stray activity=1 expected 0");
    end
  endtask

  // Stop the run if it stalls instead of reaching the summary line.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    checks = 0;
    failures = 0;
    rst = 1'b1;
    in_valid = 1'b0;
    in_a = '0;
    in_b = '0;
    in_signed = 1'b0;
    out_ready = 1'b0;
    test_reset();
    test_directed();
    test_back_to_back();
    test_back_pressure();
    test_reset_mid_op();
    run_op(64'h7F, 64'h81, 1'b1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/seq_multiplier.md
SEQ_MULTIPLIER -- requirements
Module: seq_multiplier

Interface
REQ-001 SHALL have parameter N, default 64, meaning operand width in bits; legal values are even and at least 4.
REQ-002 SHALL have parameter K, default 1, meaning operand-B bits consumed per cycle; legal values are 1, 2 and 4, and N SHALL be divisible by K.
REQ-003 SHALL have port clk, input, 1 bit: the only clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port in_valid, input, 1 bit: operands and mode are valid.
REQ-006 SHALL have port in_ready, output, 1 bit: block can accept operands.
REQ-007 SHALL have port in_a, input, N bits: multiplicand.
REQ-008 SHALL have port in_b, input, N bits: multiplier.
REQ-009 SHALL have port in_signed, input, 1 bit: 1 treats operands as two's complement, 0 as unsigned.
REQ-010 SHALL have port out_valid, output, 1 bit: out_result holds a finished product.
REQ-011 SHALL have port out_ready, input, 1 bit: consumer accepts the result.
REQ-012 SHALL have port out_result, output, 2*N bits: full-width product.
REQ-013 SHALL have port busy, output, 1 bit: high whenever the state is not IDLE.

Function
REQ-014 SHALL implement the states IDLE, BUSY and DONE; in_ready = (state==IDLE); out_valid = (state==DONE).
REQ-015 SHALL register in_a, in_b and the mode at the accept edge (in_valid && in_ready) and move IDLE->BUSY; later input changes SHALL NOT affect the result.
REQ-016 SHALL, in BUSY, shift-add K bits of the multiplier per cycle, LSB first, into a 2N-bit accumulator; a step counter SHALL run N/K cycles.
REQ-017 SHALL move BUSY->DONE on the rising edge that completes step N/K, so out_valid rises exactly N/K edges after the accept edge (64 for the defaults).
REQ-018 SHALL hold out_result and out_valid stable in DONE until out_valid && out_ready, then move DONE->IDLE with in_ready high in the following cycle; the minimum issue interval is N/K+2 cycles.
REQ-019 SHALL ignore in_valid in BUSY and DONE; no operand is lost or queued.
REQ-020 SHALL produce the exact 2N-bit product with no truncation or overflow: unsigned as zero-extended, signed as sign-extended two's complement.
REQ-021 SHALL compute a signed product by multiplying magnitudes and negating if the operand signs differ; -2^(N-1) operands SHALL give exact results.
REQ-022 SHALL make out_result all-zero whenever either operand is zero, in both modes.
REQ-023 SHALL keep out_result as the last product in IDLE, and as all-zero after reset until the first completion.

Reset
REQ-024 SHALL, when rst is sampled high, go to IDLE and clear the counter, accumulator and out_result; out_valid=0, busy=0, in_ready=1 after that edge.
REQ-025 SHALL let rst win over all events; reset during BUSY or DONE SHALL discard the operation, and no out_valid SHALL appear for it.
REQ-026 SHALL ignore in_valid in the cycle where rst is high.

Configuration
REQ-027 SHALL, with MUL_SIGNED_EN defined, support both modes as in REQ-009, REQ-020 and REQ-021.
REQ-028 SHALL, without MUL_SIGNED_EN, ignore in_signed, compute every product unsigned, and contain no sign or negation logic.

Verification
REQ-029 SHALL cover, with N=8, K=1, unsigned: a=8'hFF, b=8'hFF -> out_result=16'hFE01, out_valid 8 edges after accept.
REQ-030 SHALL cover, with N=8, K=2, MUL_SIGNED_EN, signed: a=8'hFF, b=8'hFF -> 16'h0001; a=8'h80, b=8'h01 -> 16'hFF80; a=8'h80, b=8'h80 -> 16'h4000; out_valid 4 edges after accept.
REQ-031 SHALL cover, with N=64, K=4: a=64'h0000_0001_0000_0000, b=64'h0000_0001_0000_0000 -> 128'h0000_0000_0000_0001_0000_0000_0000_0000, out_valid 16 edges after accept.
REQ-032 SHALL cover back-pressure: hold out_ready=0 for 10 cycles in DONE -> out_result and out_valid stable, in_ready=0, and a new in_valid ignored; out_ready=1 -> IDLE next cycle.
REQ-033 SHALL cover reset mid-operation: assert rst at step 3 of 8 -> IDLE with out_result=0 after the edge, and no out_valid for the aborted operation.
REQ-034 SHALL cover the build without MUL_SIGNED_EN: N=8, in_signed=1, a=8'hFF, b=8'hFF -> 16'hFE01.
